// File: rtl/operand_fetch_pkg.sv
// Shared types for the operand-fetch stage: widths, register index, shift codes, FSM states.
package operand_fetch_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_N  = 8;
    localparam int unsigned ADDR_W = $clog2(REG_N);

    typedef logic [ADDR_W-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_LSL  = 2'b01,
        SH_LSR  = 2'b10,
        SH_ASR  = 2'b11
    } shift_t;

    typedef enum logic [1:0] {
        StIdle,
        StReadA,
        StReadB,
        StDone
    } fetch_state_t;

endpackage

// File: rtl/operand_fetch_if.sv
// Instruction-in, writeback and operand-out signals of the operand-fetch stage.
interface operand_fetch_if;
    import operand_fetch_pkg::*;

    logic              in_valid;
    logic              in_ready;
    reg_addr_t         in_rn;
    reg_addr_t         in_rm;
    reg_addr_t         in_rd;
    shift_t            in_shift;
    logic              in_use_a;

    logic              wr_en;
    reg_addr_t         wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    shift_t            out_shift;
    reg_addr_t         out_rd;

    modport master (
        output in_valid, in_rn, in_rm, in_rd, in_shift, in_use_a,
        output wr_en, wr_addr, wr_data,
        output out_ready,
        input  in_ready, out_valid, out_a, out_b, out_shift, out_rd
    );

    modport slave (
        input  in_valid, in_rn, in_rm, in_rd, in_shift, in_use_a,
        input  wr_en, wr_addr, wr_data,
        input  out_ready,
        output in_ready, out_valid, out_a, out_b, out_shift, out_rd
    );

endinterface

// File: rtl/regfile_8x16.sv
// General register file: one asynchronous read port, one synchronous write port.
module regfile_8x16
    import operand_fetch_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  reg_addr_t         raddr_i,
    output logic [DATA_W-1:0] rdata_o,
    input  logic              we_i,
    input  reg_addr_t         waddr_i,
    input  logic [DATA_W-1:0] wdata_i
);

    logic [DATA_W-1:0] regs_q [REG_N];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < REG_N; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = regs_q[raddr_i];

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: reads A (optional) then B over one read port and holds them for the ALU.
module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_i,
    operand_fetch_if.slave bus
);

    fetch_state_t      state_q;
    logic              in_ready_q;
    logic              out_valid_q;
    reg_addr_t         rn_q;
    reg_addr_t         rm_q;
    reg_addr_t         rd_q;
    shift_t            shift_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;

    reg_addr_t         raddr;
    logic [DATA_W-1:0] rf_rdata;
    logic [DATA_W-1:0] rd_data;

    regfile_8x16 u_regfile (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .raddr_i (raddr),
        .rdata_o (rf_rdata),
        .we_i    (bus.wr_en),
        .waddr_i (bus.wr_addr),
        .wdata_i (bus.wr_data)
    );

    assign raddr = (state_q == StReadA) ? rn_q : rm_q;

    // Same-cycle writeback to the register being read wins over the stale array value.
    assign rd_data = (bus.wr_en && (bus.wr_addr == raddr)) ? bus.wr_data : rf_rdata;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            rn_q        <= '0;
            rm_q        <= '0;
            rd_q        <= '0;
            shift_q     <= SH_NONE;
            a_q         <= '0;
            b_q         <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        rn_q       <= bus.in_rn;
                        rm_q       <= bus.in_rm;
                        rd_q       <= bus.in_rd;
                        shift_q    <= bus.in_shift;
                        in_ready_q <= 1'b0;
                        if (bus.in_use_a) begin
                            state_q <= StReadA;
                        end else begin
                            a_q     <= '0;
                            state_q <= StReadB;
                        end
                    end
                end
                StReadA: begin
                    a_q     <= rd_data;
                    state_q <= StReadB;
                end
                StReadB: begin
                    b_q         <= rd_data;
                    out_valid_q <= 1'b1;
                    state_q     <= StDone;
                end
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_a     = a_q;
    assign bus.out_b     = b_q;
    assign bus.out_shift = shift_q;
    assign bus.out_rd    = rd_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: table of instructions plus bypass, stall, reset, back-to-back.
module tb_operand_fetch;
    import operand_fetch_pkg::*;

    logic clk;
    logic rst;

    operand_fetch_if bus ();

    operand_fetch dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic [2:0]  rn;
        logic [2:0]  rm;
        logic [2:0]  rd;
        logic [1:0]  sh;
        logic        use_a;
        logic [15:0] ea;
        logic [15:0] eb;
        int          lat;
    } vec_t;

    vec_t vecs [5];
    logic [15:0] init_regs [8];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%04h, want 0x%04h", name, act, exp);
    endtask

    task automatic write_reg(input logic [2:0] addr, input logic [15:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    // Issue at the current negedge (cycle N), return cycles until out_valid, -1 on timeout.
    task automatic run_instr(input logic [2:0] rn, input logic [2:0] rm, input logic [2:0] rd,
                             input logic [1:0] sh, input logic use_a, output int lat);
        bus.in_valid = 1'b1;
        bus.in_rn    = rn;
        bus.in_rm    = rm;
        bus.in_rd    = rd;
        bus.in_shift = shift_t'(sh);
        bus.in_use_a = use_a;
        lat = -1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) bus.in_valid = 1'b0;
            if (bus.out_valid) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic transfer(input string name);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({name, " in_ready after xfer"}, {15'd0, bus.in_ready}, 16'd1);
        chk({name, " out_valid after xfer"}, {15'd0, bus.out_valid}, 16'd0);
    endtask

    int lat;
    int vcyc [4];
    logic [15:0] va [4];
    logic [15:0] vb [4];
    int nv;

    initial begin
        vecs[0] = '{rn: 3'd2, rm: 3'd5, rd: 3'd7, sh: 2'b11, use_a: 1'b1,
                    ea: 16'h1234, eb: 16'h8001, lat: 3};
        vecs[1] = '{rn: 3'd1, rm: 3'd1, rd: 3'd0, sh: 2'b00, use_a: 1'b1,
                    ea: 16'h1111, eb: 16'h1111, lat: 3};
        vecs[2] = '{rn: 3'd0, rm: 3'd6, rd: 3'd3, sh: 2'b01, use_a: 1'b0,
                    ea: 16'h0000, eb: 16'h6666, lat: 2};
        vecs[3] = '{rn: 3'd7, rm: 3'd4, rd: 3'd5, sh: 2'b10, use_a: 1'b1,
                    ea: 16'h7777, eb: 16'h4444, lat: 3};
        vecs[4] = '{rn: 3'd3, rm: 3'd0, rd: 3'd1, sh: 2'b11, use_a: 1'b0,
                    ea: 16'h0000, eb: 16'hA0A0, lat: 2};
        init_regs = '{16'hA0A0, 16'h1111, 16'h1234, 16'h0001,
                      16'h4444, 16'h8001, 16'h6666, 16'h7777};

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_rn = '0; bus.in_rm = '0; bus.in_rd = '0;
        bus.in_shift = SH_NONE; bus.in_use_a = 1'b0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.out_ready = 1'b0;

        @(negedge clk);
        chk("reset in_ready", {15'd0, bus.in_ready}, 16'd1);
        chk("reset out_valid", {15'd0, bus.out_valid}, 16'd0);
        chk("reset out_a", bus.out_a, 16'h0000);
        chk("reset out_b", bus.out_b, 16'h0000);
        chk("reset out_shift", {14'd0, bus.out_shift}, 16'd0);
        chk("reset out_rd", {13'd0, bus.out_rd}, 16'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) write_reg(3'(i), init_regs[i]);

        for (int i = 0; i < 5; i++) begin
            run_instr(vecs[i].rn, vecs[i].rm, vecs[i].rd, vecs[i].sh, vecs[i].use_a, lat);
            chk($sformatf("vec%0d latency", i), 16'(lat), 16'(vecs[i].lat));
            chk($sformatf("vec%0d out_a", i), bus.out_a, vecs[i].ea);
            chk($sformatf("vec%0d out_b", i), bus.out_b, vecs[i].eb);
            chk($sformatf("vec%0d out_shift", i), {14'd0, bus.out_shift}, {14'd0, vecs[i].sh});
            chk($sformatf("vec%0d out_rd", i), {13'd0, bus.out_rd}, {13'd0, vecs[i].rd});
            chk($sformatf("vec%0d in_ready in DONE", i), {15'd0, bus.in_ready}, 16'd0);
            transfer($sformatf("vec%0d", i));
        end

        // use_a=0 with freshly written R5
        write_reg(3'd5, 16'h00FF);
        run_instr(3'd2, 3'd5, 3'd1, 2'b00, 1'b0, lat);
        chk("noA latency", 16'(lat), 16'd2);
        chk("noA out_a", bus.out_a, 16'h0000);
        chk("noA out_b", bus.out_b, 16'h00FF);
        transfer("noA");

        // Bypass on B: write R3 during READ_B
        bus.in_valid = 1'b1; bus.in_rn = 3'd0; bus.in_rm = 3'd3; bus.in_rd = 3'd2;
        bus.in_shift = SH_NONE; bus.in_use_a = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.wr_en = 1'b1; bus.wr_addr = 3'd3; bus.wr_data = 16'hBEEF;
        @(negedge clk);
        bus.wr_en = 1'b0;
        chk("bypassB out_valid", {15'd0, bus.out_valid}, 16'd1);
        chk("bypassB out_b", bus.out_b, 16'hBEEF);
        transfer("bypassB");
        run_instr(3'd0, 3'd3, 3'd0, 2'b00, 1'b0, lat);
        chk("R3 after bypass", bus.out_b, 16'hBEEF);
        transfer("R3 read");

        // rn==rm, independent bypass on each read
        bus.in_valid = 1'b1; bus.in_rn = 3'd6; bus.in_rm = 3'd6; bus.in_rd = 3'd4;
        bus.in_shift = SH_LSL; bus.in_use_a = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.wr_en = 1'b1; bus.wr_addr = 3'd6; bus.wr_data = 16'h2468;
        @(negedge clk);
        bus.wr_data = 16'h9ABC;
        @(negedge clk);
        bus.wr_en = 1'b0;
        chk("dual bypass out_valid", {15'd0, bus.out_valid}, 16'd1);
        chk("dual bypass out_a", bus.out_a, 16'h2468);
        chk("dual bypass out_b", bus.out_b, 16'h9ABC);
        transfer("dual bypass");

        // Backpressure with a write to rm during the stall
        run_instr(3'd1, 3'd4, 3'd2, 2'b10, 1'b1, lat);
        chk("stall latency", 16'(lat), 16'd3);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall%0d out_valid", k), {15'd0, bus.out_valid}, 16'd1);
            chk($sformatf("stall%0d in_ready", k), {15'd0, bus.in_ready}, 16'd0);
            chk($sformatf("stall%0d out_b", k), bus.out_b, 16'h4444);
            bus.wr_en = (k == 2);
            bus.wr_addr = 3'd4; bus.wr_data = 16'h5555;
            @(negedge clk);
        end
        bus.wr_en = 1'b0;
        chk("stall out_a", bus.out_a, 16'h1111);
        chk("stall out_b final", bus.out_b, 16'h4444);
        transfer("stall");
        run_instr(3'd0, 3'd4, 3'd0, 2'b00, 1'b0, lat);
        chk("R4 after stall write", bus.out_b, 16'h5555);
        transfer("R4 read");

        // Reset in READ_A, with a write attempted while reset is high
        bus.in_valid = 1'b1; bus.in_rn = 3'd2; bus.in_rm = 3'd5; bus.in_rd = 3'd7;
        bus.in_shift = SH_ASR; bus.in_use_a = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("pre-reset in_ready", {15'd0, bus.in_ready}, 16'd0);
        rst = 1'b1;
        #1;
        chk("midreset out_valid", {15'd0, bus.out_valid}, 16'd0);
        chk("midreset in_ready", {15'd0, bus.in_ready}, 16'd1);
        chk("midreset out_a", bus.out_a, 16'h0000);
        chk("midreset out_shift", {14'd0, bus.out_shift}, 16'd0);
        bus.wr_en = 1'b1; bus.wr_addr = 3'd2; bus.wr_data = 16'hFFFF;
        @(negedge clk);
        bus.wr_en = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("post-reset out_valid", {15'd0, bus.out_valid}, 16'd0);
        for (int i = 0; i < 8; i++) begin
            run_instr(3'(i), 3'(i), 3'd0, 2'b00, 1'b1, lat);
            chk($sformatf("zero R%0d out_a", i), bus.out_a, 16'h0000);
            chk($sformatf("zero R%0d out_b", i), bus.out_b, 16'h0000);
            transfer($sformatf("zero R%0d", i));
        end

        // Back-to-back with in_valid held and out_ready=1
        write_reg(3'd1, 16'h0A0A);
        write_reg(3'd2, 16'h0B0B);
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_rn = 3'd1; bus.in_rm = 3'd2; bus.in_rd = 3'd3;
        bus.in_shift = SH_NONE; bus.in_use_a = 1'b1;
        nv = 0;
        for (int c = 0; c < 12; c++) begin
            if (bus.out_valid) begin
                if (nv < 4) begin
                    vcyc[nv] = c; va[nv] = bus.out_a; vb[nv] = bus.out_b;
                end
                nv++;
            end
            if (c == 4) chk("b2b in_ready cycle4", {15'd0, bus.in_ready}, 16'd1);
            if (c == 1) begin
                bus.in_rn = 3'd2; bus.in_rm = 3'd1; bus.in_use_a = 1'b0;
            end
            if (c == 5) bus.in_valid = 1'b0;
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        chk("b2b count", 16'(nv), 16'd2);
        if (nv >= 2) begin
            chk("b2b first cycle", 16'(vcyc[0]), 16'd3);
            chk("b2b first a", va[0], 16'h0A0A);
            chk("b2b first b", vb[0], 16'h0B0B);
            chk("b2b second cycle", 16'(vcyc[1]), 16'd6);
            chk("b2b second a", va[1], 16'h0000);
            chk("b2b second b", vb[1], 16'h0A0A);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
